// File: rtl/key_debounce.sv
// Debounced push-button reader: two-flop synchroniser per key, then a per-key
// counter FSM that qualifies presses/releases and toggles an active-low LED per press.
//
// state      | meaning
// -----------+----------------------------------------------------
// IDLE       | key released and stable, counter held at 0
// DB_PRESS   | synchronised input low, counting toward a press
// HELD       | key pressed and stable, counter held at 0
// DB_RELEASE | synchronised input high, counting toward a release
module key_debounce #(
  parameter int NKEY            = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic            clk_50M,
  input  logic            rst,
  input  logic [NKEY-1:0] key_n,
  output logic [NKEY-1:0] key_state,
  output logic [NKEY-1:0] key_press,
  output logic [NKEY-1:0] key_release,
  output logic [NKEY-1:0] led_n
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_DB_PRESS   = 2'd1;
  localparam logic [1:0] S_HELD       = 2'd2;
  localparam logic [1:0] S_DB_RELEASE = 2'd3;

  logic [NKEY-1:0] sync1_q;
  logic [NKEY-1:0] sync2_q;

  // Synchroniser flops reset to the released level so a key held through reset reads as a new press.
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NKEY; i++) begin : g_key
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_d, release_d;
    logic          kstate_q, press_q, release_q, led_q;

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (!sync2_q[i]) state_d = S_DB_PRESS;
        end
        S_DB_PRESS: begin
          if (sync2_q[i]) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_HELD;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_HELD: begin
          cnt_d = '0;
          if (sync2_q[i]) state_d = S_DB_RELEASE;
        end
        S_DB_RELEASE: begin
          if (!sync2_q[i]) begin
            state_d = S_HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Level, pulses and LED all register from the next state so they change on the same edge.
    always_ff @(posedge clk_50M or negedge rst) begin
      if (!rst) begin
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        kstate_q  <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        led_q     <= 1'b1;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        kstate_q  <= (state_d == S_HELD) || (state_d == S_DB_RELEASE);
        press_q   <= press_d;
        release_q <= release_d;
        if (press_d) led_q <= ~led_q;
      end
    end

    assign key_state[i]   = kstate_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign led_n[i]       = led_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus randomized key activity, each
// cycle compared against a run-length reference model of the debounce rules.
module tb_key_debounce;
  localparam int NKEY = 4;
  localparam int DB   = 8;

  logic            clk_50M = 1'b0;
  logic            rst     = 1'b0;
  logic [NKEY-1:0] key_n   = '1;
  logic [NKEY-1:0] key_state, key_press, key_release, led_n;

  key_debounce #(.NKEY(NKEY), .DEBOUNCE_CYCLES(DB)) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .key_n      (key_n),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .led_n      (led_n)
  );

  always #10 clk_50M = ~clk_50M;

  int checks = 0;
  int errors = 0;

  // Model: the FSM sees key_n as sampled two edges earlier; a level flips once the
  // seen input has disagreed with it for DB+1 consecutive edges.
  logic [NKEY-1:0] h1, h2, m_state, m_press, m_rel, m_led;
  int run [NKEY];

  int cyc;
  int first_press, first_rel;
  logic [NKEY-1:0] first_press_vec;
  int npress [NKEY];
  int nrel [NKEY];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    h1 = '1; h2 = '1;
    m_state = '0; m_press = '0; m_rel = '0; m_led = '1;
    for (int i = 0; i < NKEY; i++) run[i] = 0;
  endtask

  task automatic model_edge();
    logic [NKEY-1:0] seen;
    if (!rst) begin
      model_reset();
      return;
    end
    seen = h2; h2 = h1; h1 = key_n;
    m_press = '0; m_rel = '0;
    for (int i = 0; i < NKEY; i++) begin
      if ((!seen[i]) != m_state[i]) run[i]++;
      else run[i] = 0;
      if (run[i] == DB + 1) begin
        m_state[i] = ~m_state[i];
        if (m_state[i]) begin
          m_press[i] = 1'b1;
          m_led[i]   = ~m_led[i];
        end else begin
          m_rel[i] = 1'b1;
        end
        run[i] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("key_state",   32'(key_state),   32'(m_state));
    check_val("key_press",   32'(key_press),   32'(m_press));
    check_val("key_release", 32'(key_release), 32'(m_rel));
    check_val("led_n",       32'(led_n),       32'(m_led));
  endtask

  task automatic clear_obs();
    first_press = -1; first_rel = -1; first_press_vec = '0;
    for (int i = 0; i < NKEY; i++) begin npress[i] = 0; nrel[i] = 0; end
  endtask

  // One clock: model follows the edge, DUT is sampled on the falling edge.
  task automatic cycle();
    @(posedge clk_50M);
    model_edge();
    cyc++;
    @(negedge clk_50M);
    check_outputs();
    for (int i = 0; i < NKEY; i++) begin
      npress[i] += int'(key_press[i]);
      nrel[i]   += int'(key_release[i]);
    end
    if (key_press != '0 && first_press < 0) begin
      first_press = cyc;
      first_press_vec = key_press;
    end
    if (key_release != '0 && first_rel < 0) first_rel = cyc;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Called at a falling edge; reset takes effect immediately, then is held n cycles.
  task automatic do_reset(input int n);
    rst = 1'b0;
    model_reset();
    #1;
    check_val("rst_state", 32'(key_state), 32'h0);
    check_val("rst_led",   32'(led_n),     32'hF);
    check_outputs();
    @(negedge clk_50M);
    cycles(n);
    rst = 1'b1;
  endtask

  initial begin
    int hold [NKEY];
    cyc = 0;
    model_reset();
    clear_obs();
    @(negedge clk_50M);
    do_reset(2);
    cycles(3);

    // Clean press on key 0
    clear_obs();
    key_n = 4'b1110; cyc = -1;
    cycles(14);
    check_val("clean_lat",   32'(first_press), 32'd10);
    check_val("clean_vec",   32'(first_press_vec), 32'b0001);
    check_val("clean_cnt",   32'(npress[0]), 32'd1);
    check_val("clean_led",   32'(led_n), 32'b1110);
    check_val("clean_state", 32'(key_state), 32'b0001);

    // Bounce rejection on key 1
    key_n = '1;
    do_reset(2);
    clear_obs();
    key_n = 4'b1101; cycles(5);
    key_n = 4'b1111; cycles(1);
    key_n = 4'b1101; cycles(5);
    key_n = 4'b1111; cycles(20);
    check_val("bounce_press", 32'(npress[1]), 32'd0);
    check_val("bounce_rel",   32'(nrel[1]),   32'd0);
    check_val("bounce_led",   32'(led_n), 32'hF);
    check_val("bounce_state", 32'(key_state), 32'h0);

    // Press / release / press on key 2
    clear_obs();
    key_n = 4'b1011; cycles(20);
    check_val("prp_led0", 32'(led_n[2]), 32'd0);
    key_n = 4'b1111; cycles(20);
    check_val("prp_state1", 32'(key_state[2]), 32'd0);
    key_n = 4'b1011; cycles(20);
    check_val("prp_press", 32'(npress[2]), 32'd2);
    check_val("prp_rel",   32'(nrel[2]),   32'd1);
    check_val("prp_led",   32'(led_n[2]),  32'd1);
    check_val("prp_state", 32'(key_state[2]), 32'd1);

    // Simultaneous press of keys 0 and 3
    key_n = '1;
    do_reset(2);
    clear_obs();
    key_n = 4'b0110; cycles(15);
    check_val("sim_vec", 32'(first_press_vec), 32'b1001);
    check_val("sim_led", 32'(led_n), 32'b0110);

    // Reset mid-debounce with key 0 held through it
    key_n = '1;
    do_reset(2);
    key_n = 4'b1110; cycles(5);
    do_reset(2);
    clear_obs();
    cyc = -1;
    cycles(14);
    check_val("rstmid_lat", 32'(first_press), 32'd10);
    check_val("rstmid_cnt", 32'(npress[0]), 32'd1);

    // Held key release on key 1
    key_n = '1;
    do_reset(2);
    key_n = 4'b1101; cycles(20);
    clear_obs();
    key_n = 4'b1111; cyc = -1;
    cycles(14);
    check_val("rel_lat",   32'(first_rel), 32'd10);
    check_val("rel_state", 32'(key_state[1]), 32'd0);
    check_val("rel_led",   32'(led_n[1]), 32'd0);

    // Randomized activity with occasional resets
    for (int i = 0; i < NKEY; i++) hold[i] = 1;
    for (int n = 0; n < 6000; n++) begin
      for (int i = 0; i < NKEY; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          key_n[i] = ~key_n[i];
          hold[i]  = int'($urandom_range(1, 2 * DB + 6));
        end
      end
      if ($urandom_range(0, 799) == 0) do_reset(int'($urandom_range(1, 3)));
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout at cycle %0d", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounced push-button reader for the MiniBoard. It is the input-side counterpart of the LED pattern drivers. It synchronises NKEY raw active-low button inputs to clk_50M and filters contact bounce with a per-key counter state machine. It produces clean level, press and release indications, plus an active-low LED register where each press toggles its own LED.

## Interface
Parameters:
- NKEY, 4: number of keys; all per-key logic is replicated NKEY times.
- DEBOUNCE_CYCLES, 1_000_000: stable-input interval in clk_50M cycles (20 ms at 50 MHz); minimum 2. Counter width is clog2(DEBOUNCE_CYCLES).

Ports:
- clk_50M  in  1  system clock, 50 MHz
- rst  in  1  reset, asynchronous, active-low
- key_n  in  NKEY  raw button inputs, active-low (0 = pressed), asynchronous to clk_50M
- key_state  out  NKEY  debounced level, 1 = pressed
- key_press  out  NKEY  one-cycle pulse on a debounced press
- key_release  out  NKEY  one-cycle pulse on a debounced release
- led_n  out  NKEY  LED drive, active-low; bit i toggles on each key_press[i]

## Operation
- Synchroniser: two flops per key. Both flops reset to 1 (released). The FSM uses only the second flop, sync_n[i].
- Per-key FSM with states IDLE, DB_PRESS, HELD and DB_RELEASE, plus a counter cnt[i]:
  - IDLE: if sync_n=0, go to DB_PRESS with cnt=0; else stay.
  - DB_PRESS: if sync_n=1, return to IDLE with cnt=0 (bounce rejected). Else if cnt==DEBOUNCE_CYCLES-1, go to HELD and register key_press=1. Else cnt+1.
  - HELD: if sync_n=1, go to DB_RELEASE with cnt=0; else stay.
  - DB_RELEASE: if sync_n=0, return to HELD with cnt=0. Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE and register key_release=1. Else cnt+1.
- key_state[i]=1 exactly when the FSM is in HELD or DB_RELEASE. It is registered and has no combinational path from key_n.
- key_press[i] and key_release[i] are registered. Each is high for exactly one cycle per qualifying transition.
- led_n[i] inverts on the edge after which key_press[i] is high, i.e. the same edge that sets the pulse. It is unaffected by release.
- Keys are fully independent. Simultaneous presses on several keys each produce their own pulse and toggle in the same cycle.
- The counter never exceeds DEBOUNCE_CYCLES-1 and is held at 0 in IDLE and HELD. Therefore no wrap-around can occur.

## Timing
- Reset (rst=0, asynchronous) sets:
  - FSM state to IDLE and cnt to 0;
  - synchroniser flops to 1;
  - key_state, key_press and key_release to 0;
  - led_n to all 1s (LEDs off).
- Reset asserted mid-debounce or mid-hold aborts the operation immediately. No pulse is emitted for the aborted operation.
- Press latency: if key_n[i] is first sampled 0 at rising edge E and stays 0, then key_press[i], key_state[i]=1 and the led_n[i] toggle all become visible after edge E+DEBOUNCE_CYCLES+2. Breakdown: 2 edges for synchronisation, 1 edge for IDLE to DB_PRESS, DEBOUNCE_CYCLES-1 counting edges, and 1 transition edge.
- Release latency is identical, measured from the first edge at which key_n[i] is sampled 1.
- Bounce rule: any sync_n reversal before the count completes restarts qualification from zero. A glitch of fewer than DEBOUNCE_CYCLES synchronised cycles never produces a pulse.
- A key held low through reset deassertion is treated as a new press. key_press fires DEBOUNCE_CYCLES+2 edges after the first edge following rst release.
- Minimum spacing between a key's press and release pulses is DEBOUNCE_CYCLES+1 cycles.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8 and NKEY=4.
- Clean press: key_n=4'b1110 from edge 0 -> key_press=4'b0001 for 1 cycle after edge 10; key_state[0]=1; led_n=4'b1110.
- Bounce rejection: key_n[1] low 5 cycles, high 1, low 5, then high -> no key_press or key_release; key_state=0; led_n unchanged at 4'b1111.
- Press/release/press on key 2, each level held 20 cycles -> key_press, key_release, key_press each one cycle wide. led_n[2] goes 0 then back to 1. key_state[2] goes high, low, high.
- Simultaneous press of keys 0 and 3 -> key_press=4'b1001 in a single cycle; led_n=4'b0110.
- Reset mid-debounce: key_n[0] low 5 cycles, then rst=0 for 2 cycles -> all outputs return to reset values immediately. With key_n[0] still low, key_press[0] fires 10 edges after the first edge following rst release.
- Held key release: after a clean press on key 1, key_n[1] goes high -> key_release[1] for 1 cycle after edge +10 and key_state[1]=0. led_n[1] stays 0.
